// File: rtl/ram_block_reader_pkg.sv
// Shared definitions for the RAM block reader: default widths common with
// the 1024x8 RAM, FSM state encoding and the read-issue admission rule.
package ram_block_reader_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_READ  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;

    // A new read may start only if every byte already owed to the FIFO
    // (stored + in flight) plus this one still fits after this cycle's pop.
    function automatic logic room_ok(
        input int occ,
        input int inflight,
        input int popped,
        input int depth
    );
        return (occ + inflight + 1 - popped) <= depth;
    endfunction

endpackage

// File: rtl/ram_block_reader_if.sv
// Byte stream with valid/ready handshake and a last-byte marker.
// master drives data/valid/last and samples ready; slave is the consumer.
interface ram_block_reader_if
    import ram_block_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush; head visible on o_data (show-ahead).
// Ports: clk, rst_n, i_push/i_data, i_pop, i_flush, o_data, o_full, o_empty, o_count.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_cnt;

    logic w_pop;
    logic w_push;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];

    // A push into a full FIFO is taken only when a pop frees a slot
    // in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/ram_block_reader.sv
// Reads a contiguous block from a 1-cycle-latency RAM and streams it out.
// Ports: clk, rst_n, i_start/i_start_addr/i_length, i_abort, RAM port
// (o_ram_we, o_ram_addr, o_ram_din, i_ram_dout), o_strm stream, o_busy, o_done.
module ram_block_reader
    import ram_block_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W:0]   i_length,
    input  logic              i_abort,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    ram_block_reader_if.master o_strm,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_popped;
    logic              r_inflight;
    logic              r_done_evt;

    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_cnt;

    logic w_start_ok;
    logic w_start_go;
    logic w_start_zero;
    logic w_active;
    logic w_fin;
    logic w_abort;
    logic w_pop;
    logic w_push;
    logic w_room;
    logic w_issue;
    logic w_last_issue;

    assign w_start_ok   = (r_state == S_IDLE) && i_start;
    assign w_start_go   = w_start_ok && (i_length != '0);
    assign w_start_zero = w_start_ok && (i_length == '0);
    assign w_active     = (r_state != S_IDLE);

    // Transfer completes once everything owed to the consumer has left.
    assign w_fin = (r_state == S_DRAIN) && w_fifo_empty && !r_inflight;

    // An abort landing on the completion cycle would double the done pulse.
    assign w_abort = i_abort && w_active && !w_fin;

    assign w_pop  = !w_fifo_empty && o_strm.ready && !w_abort;
    assign w_push = r_inflight && !w_abort;

    assign w_room = room_ok(int'(w_fifo_cnt), int'(r_inflight),
                            int'(w_pop), FIFO_DEPTH);

    assign w_issue = (r_state == S_READ) && !w_abort &&
                     (r_issued < r_len) && w_room;

    assign w_last_issue = w_issue && ((r_issued + 1'b1) == r_len);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (i_ram_dout),
        .i_pop   (w_pop),
        .i_flush (w_abort),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_start_go)   w_next = S_READ;
                S_READ:  if (w_last_issue) w_next = S_DRAIN;
                S_DRAIN: if (w_fin)        w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_ram_addr <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_done_evt <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done_evt <= w_abort || w_start_zero;
            if (w_start_go) begin
                r_addr   <= i_start_addr;
                r_len    <= i_length;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue) begin
                    r_ram_addr <= r_addr;
                    r_addr     <= r_addr + 1'b1;
                    r_issued   <= r_issued + 1'b1;
                end
                if (w_pop) r_popped <= r_popped + 1'b1;
            end
        end
    end

    // The address goes straight to the RAM in the issue cycle so the byte
    // returns on the next edge; between issues the bus holds the last one.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_din   = '0;
        o_ram_addr  = w_issue ? r_addr : r_ram_addr;
        o_strm.valid = !w_fifo_empty;
        o_strm.data  = w_fifo_empty ? '0 : w_fifo_data;
        o_strm.last  = !w_fifo_empty && (r_popped == (r_len - 1'b1));
        o_done      = w_fin || r_done_evt;
        o_busy      = w_active && !w_fin;
    end

endmodule

// File: tb/tb_ram_block_reader.sv
// Randomised bench for ram_block_reader: behavioural RAM, expected stream
// derived from RAM contents and start/length, per-feature check tasks.
module tb_ram_block_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic        abort;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_block_reader_if #(.DATA_W(8)) strm ();

    ram_block_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_length     (length),
        .i_abort      (abort),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_din    (ram_din),
        .i_ram_dout   (ram_dout),
        .o_strm       (strm),
        .o_busy       (busy),
        .o_done       (done)
    );

    logic [7:0] mem [1024];
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_d [$];
    bit         got_l [$];
    int         got_c [$];
    int         done_n = 0;
    int         done_c = 0;
    int         busy_n = 0;
    int         stall_bad = 0;
    logic [9:0] addr_at [4096];
    bit         valid_at [4096];
    bit         pv = 0, pr = 0, pl = 0, pa = 0;
    logic [7:0] pd = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            addr_at[cyc & 4095]  = ram_addr;
            valid_at[cyc & 4095] = strm.valid;
            if (strm.valid && strm.ready && !abort) begin
                got_d.push_back(strm.data);
                got_l.push_back(strm.last);
                got_c.push_back(cyc);
            end
            if (done) begin
                done_n++;
                done_c = cyc;
            end
            if (busy) busy_n++;
            if (pv && !pr && !pa &&
                (strm.valid !== 1'b1 || strm.data !== pd || strm.last !== pl))
                stall_bad++;
            pv = strm.valid;
            pr = strm.ready;
            pd = strm.data;
            pl = strm.last;
            pa = abort;
        end else begin
            pv = 0;
        end
    end

    int c0, gb, db, bb, sb, ca;
    bit pat_go;
    bit pat [$];

    task automatic drive_ready(input int mode);
        if (mode == 0) begin
            strm.ready = 1'b1;
        end else if (mode == 1) begin
            if (!pat_go && strm.valid) pat_go = 1;
            if (pat_go && pat.size() > 0) strm.ready = pat.pop_front();
            else strm.ready = 1'b1;
        end else begin
            strm.ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic run_xfer(input int a, input int n, input int mode,
                            input int abort_pops, input int restart_off,
                            output bit tmo);
        int k;
        bit ab;
        k  = 0;
        ab = 0;
        @(posedge clk); #1;
        c0 = cyc; gb = got_d.size(); db = done_n;
        bb = busy_n; sb = stall_bad; ca = -1; pat_go = 0;
        start = 1'b1;
        start_addr = a[9:0];
        length = n[10:0];
        drive_ready(mode);
        while (done_n == db && k < 3000) begin
            @(posedge clk); #1;
            k++;
            start = (k == restart_off);
            if (start) begin
                start_addr = ~a[9:0];
                length = 11'd5;
            end
            abort = 1'b0;
            if (abort_pops >= 0 && !ab && (got_d.size() - gb) >= abort_pops) begin
                abort = 1'b1;
                ab = 1;
                ca = cyc;
            end
            drive_ready(mode);
        end
        start = 1'b0;
        abort = 1'b0;
        tmo = (done_n == db);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        start = 0; abort = 0; start_addr = 0; length = 0;
        strm.ready = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        #1;
        checks += 8;
        if (strm.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", strm.valid); end
        if (strm.last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", strm.last); end
        if (strm.data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", strm.data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", ram_addr); end
        if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", ram_we); end
        if (ram_din !== 8'h00) begin errors++; $display("FAIL rst_din got %h exp 00", ram_din); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic;
        bit tmo;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h05; exp_b[1] = 8'h15; exp_b[2] = 8'hA3;
        mem[0] = 8'h05; mem[1] = 8'h15; mem[2] = 8'hA3;
        run_xfer(0, 3, 0, -1, -1, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
        checks++;
        if (got_d.size() - gb != 3) begin
            errors++; $display("FAIL basic_count got %0d exp 3", got_d.size() - gb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 3;
                if (got_d[gb+i] !== exp_b[i]) begin
                    errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got_d[gb+i], exp_b[i]);
                end
                if (got_l[gb+i] !== (i == 2)) begin
                    errors++; $display("FAIL basic_last%0d got %b exp %b", i, got_l[gb+i], i == 2);
                end
                if (got_c[gb+i] != c0 + 3 + i) begin
                    errors++; $display("FAIL basic_cycle%0d got %0d exp %0d", i, got_c[gb+i] - c0, 3 + i);
                end
            end
            checks++;
            if (done_c != got_c[gb+2] + 1) begin
                errors++; $display("FAIL basic_done_cycle got %0d exp %0d", done_c - c0, 6);
            end
        end
        checks += 3;
        if (done_n - db != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_n - db); end
        if (busy_n - bb != 5) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 5", busy_n - bb); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_wrap;
        bit tmo;
        logic [9:0] ea [3];
        logic [7:0] eb [3];
        ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0;
        eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h33;
        mem[1022] = 8'h11; mem[1023] = 8'h22; mem[0] = 8'h33;
        run_xfer(1022, 3, 0, -1, -1, tmo);
        checks += 2;
        if (tmo) begin errors++; $display("FAIL wrap_timeout got no done exp done"); end
        if (got_d.size() - gb != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", got_d.size() - gb); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_at[(c0 + 1 + i) & 4095] !== ea[i]) begin
                errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, addr_at[(c0 + 1 + i) & 4095], ea[i]);
            end
            if (got_d.size() - gb == 3) begin
                checks += 2;
                if (got_d[gb+i] !== eb[i]) begin
                    errors++; $display("FAIL wrap_byte%0d got %h exp %h", i, got_d[gb+i], eb[i]);
                end
                if (got_l[gb+i] !== (i == 2)) begin
                    errors++; $display("FAIL wrap_last%0d got %b exp %b", i, got_l[gb+i], i == 2);
                end
            end
        end
    endtask

    task automatic test_zero_len;
        bit tmo;
        run_xfer(37, 0, 0, -1, -1, tmo);
        checks += 5;
        if (tmo) begin errors++; $display("FAIL zero_timeout got no done exp done"); end
        if (done_n - db != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_n - db); end
        if (done_c != c0 + 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_c - c0); end
        if (busy_n != bb) begin errors++; $display("FAIL zero_busy got %0d cycles exp 0", busy_n - bb); end
        if (got_d.size() != gb) begin errors++; $display("FAIL zero_bytes got %0d exp 0", got_d.size() - gb); end
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (addr_at[(c0 + i) & 4095] !== 10'd0) begin
                errors++; $display("FAIL zero_addr%0d got %0d exp 0", i, addr_at[(c0 + i) & 4095]);
            end
            if (valid_at[(c0 + i) & 4095] !== 1'b0) begin
                errors++; $display("FAIL zero_valid%0d got 1 exp 0", i);
            end
        end
    endtask

    task automatic test_backpressure;
        bit tmo;
        int a;
        a = $urandom_range(0, 1023);
        pat = '{1, 0, 0, 1, 0, 1, 1};
        run_xfer(a, 4, 1, -1, -1, tmo);
        checks += 4;
        if (tmo) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
        if (got_d.size() - gb != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_d.size() - gb); end
        if (stall_bad != sb) begin errors++; $display("FAIL bp_stall_hold got %0d violations exp 0", stall_bad - sb); end
        if (done_n - db != 1) begin errors++; $display("FAIL bp_done_count got %0d exp 1", done_n - db); end
        if (got_d.size() - gb == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (got_d[gb+i] !== mem[(a + i) % 1024]) begin
                    errors++; $display("FAIL bp_byte%0d got %h exp %h", i, got_d[gb+i], mem[(a + i) % 1024]);
                end
                if (got_l[gb+i] !== (i == 3)) begin
                    errors++; $display("FAIL bp_last%0d got %b exp %b", i, got_l[gb+i], i == 3);
                end
            end
        end
    endtask

    task automatic test_random;
        bit tmo;
        int a, n, mode;
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
            a = $urandom_range(0, 1023);
            n = (t == 8) ? 1024 : $urandom_range(1, 40);
            mode = (t == 8) ? 0 : 2;
            run_xfer(a, n, mode, -1, -1, tmo);
            checks += 4;
            if (tmo) begin errors++; $display("FAIL rand%0d_timeout got no done exp done", t); end
            if (got_d.size() - gb != n) begin
                errors++; $display("FAIL rand%0d_count got %0d exp %0d", t, got_d.size() - gb, n);
            end
            if (stall_bad != sb) begin errors++; $display("FAIL rand%0d_stall_hold got %0d exp 0", t, stall_bad - sb); end
            if (done_n - db != 1) begin errors++; $display("FAIL rand%0d_done_count got %0d exp 1", t, done_n - db); end
            if (got_d.size() - gb == n) begin
                for (int i = 0; i < n; i++) begin
                    checks += 2;
                    if (got_d[gb+i] !== mem[(a + i) % 1024]) begin
                        errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", t, i, got_d[gb+i], mem[(a + i) % 1024]);
                    end
                    if (got_l[gb+i] !== (i == n - 1)) begin
                        errors++; $display("FAIL rand%0d_last%0d got %b exp %b", t, i, got_l[gb+i], i == n - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_abort;
        bit tmo;
        int a;
        a = $urandom_range(0, 1023);
        run_xfer(a, 8, 0, 2, -1, tmo);
        checks += 6;
        if (tmo) begin errors++; $display("FAIL abort_timeout got no done exp done"); end
        if (got_d.size() - gb != 2) begin errors++; $display("FAIL abort_count got %0d exp 2", got_d.size() - gb); end
        if (valid_at[ca & 4095] !== 1'b1) begin errors++; $display("FAIL abort_valid_before got 0 exp 1"); end
        if (valid_at[(ca + 1) & 4095] !== 1'b0) begin errors++; $display("FAIL abort_valid_after got 1 exp 0"); end
        if (done_n - db != 1 || done_c != ca + 1) begin
            errors++; $display("FAIL abort_done got %0d pulses at +%0d exp 1 at +1", done_n - db, done_c - ca);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        if (got_d.size() - gb == 2) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_d[gb+i] !== mem[(a + i) % 1024]) begin
                    errors++; $display("FAIL abort_byte%0d got %h exp %h", i, got_d[gb+i], mem[(a + i) % 1024]);
                end
            end
        end
        run_xfer(16, 1, 0, -1, -1, tmo);
        checks += 3;
        if (tmo) begin errors++; $display("FAIL post_abort_timeout got no done exp done"); end
        if (got_d.size() - gb != 1) begin
            errors++; $display("FAIL post_abort_count got %0d exp 1", got_d.size() - gb);
        end else begin
            if (got_d[gb] !== mem[16]) begin
                errors++; $display("FAIL post_abort_byte got %h exp %h", got_d[gb], mem[16]);
            end
            if (got_l[gb] !== 1'b1) begin
                errors++; $display("FAIL post_abort_last got %b exp 1", got_l[gb]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit tmo;
        int a, a2;
        a = $urandom_range(100, 900);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a[9:0]; length = 11'd20; strm.ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks += 6;
        if (strm.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", strm.valid); end
        if (strm.last !== 1'b0) begin errors++; $display("FAIL mid_rst_last got %b exp 0", strm.last); end
        if (strm.data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h exp 00", strm.data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", done); end
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL mid_rst_addr got %0d exp 0", ram_addr); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (strm.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stays_empty got %b exp 0", strm.valid); end
        a2 = $urandom_range(0, 1023);
        run_xfer(a2, 6, 0, -1, 2, tmo);
        checks += 3;
        if (tmo) begin errors++; $display("FAIL ignore_timeout got no done exp done"); end
        if (done_n - db != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", done_n - db); end
        if (got_d.size() - gb != 6) begin
            errors++; $display("FAIL ignore_count got %0d exp 6", got_d.size() - gb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_d[gb+i] !== mem[(a2 + i) % 1024]) begin
                    errors++; $display("FAIL ignore_byte%0d got %h exp %h", i, got_d[gb+i], mem[(a2 + i) % 1024]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_zero_len;
        test_backpressure;
        test_abort;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
